// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the framebuffer scanout, draw and clear blocks,
// plus the sync/active flag bundle carried down the read-alignment pipeline.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;
  localparam int FB_PIXELS        = VGA_H_ACTIVE * VGA_V_ACTIVE;

  // Syncs are active-low, so the idle bundle has both syncs high.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } scan_flags_t;

  localparam scan_flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Raster position counters and raw (undelayed) VGA position flags.
// Everything advances only on pixel_en ticks.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pixel_en_i,
  output logic active_o,
  output logic last_active_o,
  output logic hs_raw_o,
  output logic vs_raw_o,
  output logic frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pixel_en_i) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign last_active_o = (h_cnt_q == H_ACT_LAST) && (v_cnt_q == V_ACT_LAST);
  assign hs_raw_o      = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
  assign vs_raw_o      = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  // Gated by reset so the pulse can never coincide with a reset edge.
  assign frame_start_o = rst_n_i && pixel_en_i && h_last && v_last;

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster-order framebuffer reader: issues linear read addresses and re-aligns the
// returned pixel with sync/blank flags delayed by the memory read latency.
module framebuffer_scanout
  import vga_timing_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 19,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixel_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  video_on,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  frame_start
);

  logic        active, last_active;
  scan_flags_t raw;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i         (clk),
    .rst_n_i       (rst),
    .pixel_en_i    (pixel_en),
    .active_o      (active),
    .last_active_o (last_active),
    .hs_raw_o      (raw.hs),
    .vs_raw_o      (raw.vs),
    .frame_start_o (frame_start)
  );

  assign raw.act   = active;
  assign mem_rd_en = pixel_en && active;

  // Address tracks v*H_ACTIVE+h at active positions; blanking leaves it parked.
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  always_comb begin
    mem_addr_d = mem_addr_q;
    if (mem_rd_en) mem_addr_d = last_active ? '0 : mem_addr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) mem_addr_q <= '0;
    else      mem_addr_q <= mem_addr_d;
  end

  assign mem_addr = mem_addr_q;

  scan_flags_t pipe_q [1:RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i <= RD_LATENCY; i++) pipe_q[i] <= FLAGS_IDLE;
    end else if (pixel_en) begin
      pipe_q[1] <= raw;
      for (int i = 2; i <= RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Blanking tap lines up with the data word arriving on mem_data this tick.
  logic act_tap;
  generate
    if (RD_LATENCY == 1) begin : g_tap_raw
      assign act_tap = active;
    end else begin : g_tap_pipe
      assign act_tap = pipe_q[RD_LATENCY-1].act;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] pixel_q, pixel_d;

  assign pixel_d = act_tap ? mem_data : '0;

  always_ff @(posedge clk) begin
    if (!rst)          pixel_q <= '0;
    else if (pixel_en) pixel_q <= pixel_d;
  end

  assign hsync     = pipe_q[RD_LATENCY].hs;
  assign vsync     = pipe_q[RD_LATENCY].vs;
  assign video_on  = pipe_q[RD_LATENCY].act;
  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: full-size 640x480 instance (read latency 1, async memory)
// and a shrunken-raster instance (read latency 2, registered memory) driven in lockstep.
module tb_framebuffer_scanout;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lat;
  } tcfg_t;

  logic clk = 1'b0;
  logic rst, pixel_en;
  always #5 clk = ~clk;

  logic [18:0] a_addr, b_addr;
  logic        a_rd, b_rd, a_hs, b_hs, a_vs, b_vs, a_von, b_von, a_fs, b_fs;
  logic        a_mem, b_mem_q, a_pix, b_pix;

  framebuffer_scanout #(.RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .mem_addr(a_addr), .mem_rd_en(a_rd),
    .mem_data(a_mem), .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .pixel_out(a_pix),
    .frame_start(a_fs)
  );

  framebuffer_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(2)
  ) dut_b (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .mem_addr(b_addr), .mem_rd_en(b_rd),
    .mem_data(b_mem_q), .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .pixel_out(b_pix),
    .frame_start(b_fs)
  );

  // Pattern memory: data = addr[0]. A reads asynchronously, B through one register.
  assign a_mem = a_addr[0];
  always @(posedge clk) if (b_rd) b_mem_q <= b_addr[0];

  tcfg_t ca, cb;
  int    n_chk = 0, n_pass = 0;
  int    p = 0;
  bit    cnt_en = 0;
  int    a_hs_low = 0, b_vs_low = 0, b_fs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int ht(tcfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
  function automatic int vt(tcfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction
  function automatic int hpos(tcfg_t c, int q); return (q % (ht(c) * vt(c))) % ht(c); endfunction
  function automatic int vpos(tcfg_t c, int q); return (q % (ht(c) * vt(c))) / ht(c); endfunction
  function automatic bit act(tcfg_t c, int q);
    return hpos(c, q) < c.ha && vpos(c, q) < c.va;
  endfunction
  function automatic bit is_last(tcfg_t c, int q);
    return hpos(c, q) == ht(c) - 1 && vpos(c, q) == vt(c) - 1;
  endfunction
  // Address sitting on the port at position q: active pixels already read this frame.
  function automatic int exp_addr(tcfg_t c, int q);
    int h, v, x;
    h = hpos(c, q);
    v = vpos(c, q);
    x = (v < c.va) ? v * c.ha + ((h < c.ha) ? h : c.ha) : 0;
    if (x == c.ha * c.va) x = 0;
    return x;
  endfunction

  task automatic chk_comb(input string nm, input tcfg_t c, input logic r, input logic pe,
                          input logic [18:0] addr, input logic rd, input logic fs);
    chk({nm, "_addr"}, addr, exp_addr(c, p));
    chk({nm, "_rd_en"}, rd, pe & act(c, p));
    chk({nm, "_frame_start"}, fs, r & pe & is_last(c, p));
  endtask

  task automatic chk_reg(input string nm, input tcfg_t c, input logic [18:0] addr,
                         input logic hs, input logic vs, input logic von, input logic pix);
    logic ehs, evs, evon, epix;
    int   q, h, v;
    ehs = 1; evs = 1; evon = 0; epix = 0;
    if (p >= c.lat) begin
      q    = p - c.lat;
      h    = hpos(c, q);
      v    = vpos(c, q);
      ehs  = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hs);
      evs  = !(v >= c.va + c.vf && v < c.va + c.vf + c.vs);
      evon = act(c, q);
      epix = evon ? logic'((v * c.ha + h) % 2) : 1'b0;
    end
    chk({nm, "_addr_r"}, addr, exp_addr(c, p));
    chk({nm, "_hsync"}, hs, ehs);
    chk({nm, "_vsync"}, vs, evs);
    chk({nm, "_video_on"}, von, evon);
    chk({nm, "_pixel_out"}, pix, epix);
  endtask

  task automatic step(input logic r, input logic pe);
    rst = r;
    pixel_en = pe;
    #1;
    chk_comb("a", ca, r, pe, a_addr, a_rd, a_fs);
    chk_comb("b", cb, r, pe, b_addr, b_rd, b_fs);
    if (cnt_en) b_fs_cnt += int'(b_fs);
    @(posedge clk);
    if (!r) p = 0;
    else if (pe) p++;
    @(negedge clk);
    chk_reg("a", ca, a_addr, a_hs, a_vs, a_von, a_pix);
    chk_reg("b", cb, b_addr, b_hs, b_vs, b_von, b_pix);
    if (cnt_en) begin
      a_hs_low += int'(!a_hs);
      b_vs_low += int'(!b_vs);
    end
    if (p == 800) chk("a_line1_first_addr", a_addr, 640);
    if (p == 55)  chk("b_last_active_addr", b_addr, 31);
    if (p == 56)  chk("b_addr_wrap", b_addr, 0);
  endtask

  initial begin
    ca = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, lat: 1};
    cb = '{ha: 8, hf: 2, hs: 3, hb: 3, va: 4, vf: 1, vs: 2, vb: 1, lat: 2};

    rst = 0;
    pixel_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reg("a_rst", ca, a_addr, a_hs, a_vs, a_von, a_pix);
    chk_reg("b_rst", cb, b_addr, b_hs, b_vs, b_von, b_pix);

    // Continuous pixel ticks: three full 800-tick lines on A, ~19 frames on B.
    cnt_en = 1;
    for (int i = 0; i < 2500; i++) step(1'b1, 1'b1);
    cnt_en = 0;
    chk("a_hsync_low_ticks", a_hs_low, 288);
    chk("b_vsync_low_ticks", b_vs_low, 608);
    chk("b_frame_start_pulses", b_fs_cnt, 19);

    // Half-rate pixel ticks; everything must hold on the idle clocks.
    for (int i = 0; i < 400; i++) step(1'b1, (i % 2) == 0);

    // One-clock reset mid-line (A sits at h=300 here).
    step(1'b0, 1'b1);
    chk("a_midreset_addr", a_addr, 0);
    chk("a_midreset_video_on", a_von, 0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
